// File: rtl/q_stage_ctrl.sv
// -----------------------------------------------------------------------------
// q_stage_ctrl
//
// Downstream controller for a bank of WIDTH q_flop cells. A word offered by
// upstream (valid/ready) is clocked into the bank by holding qf_clock high for
// SAMPLE_CYCLES cycles. The controller then waits for every cell to report
// quiescence on qf_ack, captures qf_out and presents it to the next stage
// (valid/ready).
//
// Optional feature (compile-time macro QSTAGE_TIMEOUT_EN):
//   When defined, a resolve wait that reaches TIMEOUT cycles without a full
//   ack pulses timeout_err for one cycle and re-clocks the bank. Retries are
//   unbounded. When undefined, the controller waits indefinitely,
//   timeout_err is tied to 0 and no timeout logic exists.
//
// Parameters:
//   WIDTH         number of q_flop cells and data width
//   SAMPLE_CYCLES cycles qf_clock is held high per sample (1..15)
//   SYNC_STAGES   depth of the qf_ack synchronizer (2..4)
//   TIMEOUT       resolve-wait limit in cycles (timeout build only)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_l      in   asynchronous active-low reset (release is synchronised)
//   in_valid     in   upstream word present on the q_flop data inputs
//   in_ready     out  controller idle and able to accept a sample
//   qf_clock     out  registered clock to all q_flop cells
//   qf_ack       in   per-cell quiescence flags, asynchronous to clock
//   qf_out       in   per-cell resolved outputs
//   out_valid    out  out_data holds a resolved word
//   out_ready    in   downstream accepts out_data
//   out_data     out  captured resolved word
//   timeout_err  out  one-cycle pulse on resolve timeout
// -----------------------------------------------------------------------------
module q_stage_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             qf_clock,
  input  logic [WIDTH-1:0] qf_ack,
  input  logic [WIDTH-1:0] qf_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             timeout_err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality check
  // ---------------------------------------------------------------------------
  generate
    if ((SAMPLE_CYCLES < 1) || (SAMPLE_CYCLES > 15) ||
        (SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
        (TIMEOUT <= SYNC_STAGES)) begin : g_param_check
      $error("q_stage_ctrl: illegal parameter combination");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  localparam int SCNT_W = 4;

  // The wait counter only has to reach the ack mask depth unless the timeout
  // feature needs it to count further.
`ifdef QSTAGE_TIMEOUT_EN
  localparam int WAIT_MAX = (TIMEOUT > SYNC_STAGES) ? TIMEOUT : SYNC_STAGES;
`else
  localparam int WAIT_MAX = SYNC_STAGES;
`endif
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [1:0]        rst_sync_r;
  logic              rst_n_s;

  logic [WIDTH-1:0]  ack_sync_r [SYNC_STAGES];
  logic [WIDTH-1:0]  ack_s;
  logic              ack_all_s;
  logic              ack_ok_s;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [SCNT_W-1:0] sample_cnt_r;
  logic              sample_done_s;
  logic [WCNT_W-1:0] wait_cnt_r;

  logic              qf_clock_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              in_ready_s;

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assertion is immediate, release is aligned to clock so
  // every flop below leaves reset on the same edge.
  // ---------------------------------------------------------------------------
  // Two-flop reset release synchronizer
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // ---------------------------------------------------------------------------
  // qf_ack synchronizer. qf_out is deliberately not synchronised: it is only
  // sampled once every synchronised ack bit is set, at which point the cells
  // have stopped switching.
  // ---------------------------------------------------------------------------
  // Multi-stage ack synchronizer
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ack_sync_r[i] <= '0;
      end
    end else begin
      ack_sync_r[0] <= qf_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sync_r[i] <= ack_sync_r[i-1];
      end
    end
  end

  assign ack_s     = ack_sync_r[SYNC_STAGES-1];
  assign ack_all_s = &ack_s;

  // Acks seen within the first SYNC_STAGES cycles of RESOLVE may still be the
  // pre-sample values working their way through the synchronizer.
  assign ack_ok_s = (wait_cnt_r >= WCNT_W'(SYNC_STAGES)) && ack_all_s;

  // ---------------------------------------------------------------------------
  // Sample counter: counts edges spent in SAMPLE, zero elsewhere, so it is
  // cleared on every (re)entry into SAMPLE.
  // ---------------------------------------------------------------------------
  // Sample window counter
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sample_cnt_r <= {SCNT_W{1'b0}};
    end else if (state_r == ST_SAMPLE) begin
      sample_cnt_r <= sample_cnt_r + {{(SCNT_W-1){1'b0}}, 1'b1};
    end else begin
      sample_cnt_r <= {SCNT_W{1'b0}};
    end
  end

  assign sample_done_s = (sample_cnt_r == SCNT_W'(SAMPLE_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // Wait counter: zero outside RESOLVE (hence zero on entry), increments each
  // RESOLVE cycle and saturates so it can never wrap back into the mask window.
  // ---------------------------------------------------------------------------
  // Resolve wait counter
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end else if (state_r == ST_RESOLVE) begin
      if (wait_cnt_r != WCNT_W'(WAIT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout detection (optional)
  // ---------------------------------------------------------------------------
`ifdef QSTAGE_TIMEOUT_EN
  logic timeout_hit_s;
  logic timeout_err_r;

  // Fires on the edge where the counter would reach TIMEOUT, so RESOLVE lasts
  // exactly TIMEOUT cycles before a retry. A full ack on that edge wins.
  assign timeout_hit_s = (state_r == ST_RESOLVE) && !ack_ok_s &&
                         (wait_cnt_r == WCNT_W'(TIMEOUT - 1));

  // Registered one-cycle timeout pulse
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_hit_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (sample_done_s) begin
          state_nxt_s = ST_RESOLVE;
        end else begin
          state_nxt_s = ST_SAMPLE;
        end
      end
      ST_RESOLVE: begin
        if (ack_ok_s) begin
          state_nxt_s = ST_PRESENT;
`ifdef QSTAGE_TIMEOUT_EN
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_SAMPLE;
`endif
        end else begin
          state_nxt_s = ST_RESOLVE;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PRESENT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready only while idle (no same-cycle bypass)
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == ST_IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign in_ready = in_ready_s;

  // ---------------------------------------------------------------------------
  // Registered outputs. qf_clock and out_valid are flops driven from the next
  // state, so qf_clock cannot glitch and both track the FSM with no lag.
  // ---------------------------------------------------------------------------
  // Output registers and data capture
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      qf_clock_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      qf_clock_r  <= (state_nxt_s == ST_SAMPLE);
      out_valid_r <= (state_nxt_s == ST_PRESENT);
      if ((state_r == ST_RESOLVE) && ack_ok_s) begin
        out_data_r <= qf_out;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign qf_clock  = qf_clock_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_q_stage_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for q_stage_ctrl (default parameters, TIMEOUT=16).
// Expected words are queued when a transaction is started and checked by a
// monitor whenever a word leaves the DUT. Timing is checked inline per task.
// -----------------------------------------------------------------------------
module tb_q_stage_ctrl;

  localparam int WIDTH = 8;
  localparam int SC    = 2;
  localparam int SS    = 2;
  localparam int TO    = 16;

  logic             clock = 1'b0;
  logic             reset_l = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             qf_clock;
  logic [WIDTH-1:0] qf_ack = 8'hFF;
  logic [WIDTH-1:0] qf_out = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             timeout_err;

  int               n_tests = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sb_exp;

  q_stage_ctrl #(
    .WIDTH(WIDTH), .SAMPLE_CYCLES(SC), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready),
    .qf_clock(qf_clock), .qf_ack(qf_ack), .qf_out(qf_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: a word transfers on the next rising edge
  always @(negedge clock) begin
    if (reset_l && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_data=%h delivered, expected no word", out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_data !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_data: out_data=%h expected %h", out_data, sb_exp);
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out_valid(input string name, input int max_cycles);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < max_cycles) begin
      step();
      k++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, expected 1", name, out_valid, k);
    end
  endtask

  task automatic test_reset;
    reset_l = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if ({in_ready, out_valid, qf_clock, timeout_err} !== 4'b1000 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: rdy/vld/qfclk/terr=%b%b%b%b data=%h expected 1000 00",
               in_ready, out_valid, qf_clock, timeout_err, out_data);
    end
    reset_l = 1'b1;
    repeat (4) step();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_nominal(input logic [WIDTH-1:0] w);
    qf_ack = 8'hFF;
    qf_out = w;
    in_valid = 1'b1;
    exp_q.push_back(w);
    step(); // acceptance edge
    n_tests++;
    if (qf_clock !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_accept: qf_clock=%b in_ready=%b expected 1 0", qf_clock, in_ready);
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (qf_clock !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_qfclk_hi: qf_clock=%b expected 1", qf_clock);
    end
    step();
    n_tests++;
    if (qf_clock !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_qfclk_lo: qf_clock=%b expected 0", qf_clock);
    end
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_early_valid: out_valid=%b at edge 4 expected 0", out_valid);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== w) begin
      n_fail++;
      $display("FAIL nom_latency: out_valid=%b out_data=%h at edge 5 expected 1 %h", out_valid, out_data, w);
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_partial_ack;
    qf_ack = 8'h7F;
    qf_out = 8'h00;
    in_valid = 1'b1;
    exp_q.push_back(8'h3C);
    step();
    in_valid = 1'b0;
    step();
    step(); // now in RESOLVE
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_hold: out_valid=%b in cycle %0d expected 0", out_valid, i);
      end
    end
    qf_ack = 8'hFF;
    qf_out = 8'h3C;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_sync: out_valid=%b %0d edges after full ack expected 0", out_valid, SS);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL partial_capture: out_valid=%b out_data=%h expected 1 3c", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_idle: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_backpressure;
    qf_ack = 8'hFF;
    qf_out = 8'h5A;
    in_valid = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    in_valid = 1'b0;
    wait_out_valid("bp", 20);
    for (int i = 0; i < 7; i++) begin
      qf_out = 8'($urandom_range(0, 255));
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || in_ready !== 1'b0 || qf_clock !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable: vld=%b data=%h rdy=%b qfclk=%b expected 1 5a 0 0",
                 out_valid, out_data, in_ready, qf_clock);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n_acc;
    int last_acc;
    int idle_cnt;
    int k;
    logic acc;
    qf_ack = 8'hFF;
    qf_out = 8'h01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    in_valid = 1'b1;
    out_ready = 1'b1;
    n_acc = 0;
    last_acc = -1;
    idle_cnt = 0;
    for (int cyc = 0; cyc < 60 && n_acc < 3; cyc++) begin
      acc = in_ready;
      step();
      if (acc) begin
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc != SC + SS + 3 || idle_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: accept gap=%0d idle cycles=%0d expected %0d 1",
                     cyc - last_acc, idle_cnt, SC + SS + 3);
          end
        end
        last_acc = cyc;
        idle_cnt = 0;
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
      end
      if (in_ready) begin
        idle_cnt++;
        if (n_acc < 3) qf_out = 8'(n_acc + 1);
      end
    end
    n_tests++;
    if (n_acc != 3) begin
      n_fail++;
      $display("FAIL b2b_accepts: %0d accepts expected 3", n_acc);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d words outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_resolve_wait;
`ifdef QSTAGE_TIMEOUT_EN
    int last_p;
    int n_p;
`endif
    qf_ack = 8'h00;
    qf_out = 8'h77;
    in_valid = 1'b1;
    exp_q.push_back(8'h77);
    step();
    in_valid = 1'b0;
`ifdef QSTAGE_TIMEOUT_EN
    last_p = -1;
    n_p = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (timeout_err === 1'b1) begin
        n_tests++;
        if (qf_clock !== 1'b1 || (last_p >= 0 && c - last_p != TO + SC)) begin
          n_fail++;
          $display("FAIL to_pulse: qf_clock=%b period=%0d expected 1 %0d", qf_clock, c - last_p, TO + SC);
        end
        last_p = c;
        n_p++;
      end
    end
    n_tests++;
    if (n_p != 3) begin
      n_fail++;
      $display("FAIL to_count: %0d timeout pulses in 60 cycles expected 3", n_p);
    end
`else
    for (int c = 0; c < 60; c++) begin
      step();
      n_tests++;
      if (timeout_err !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_noack: timeout_err=%b out_valid=%b expected 0 0", timeout_err, out_valid);
      end
    end
`endif
    qf_ack = 8'hFF;
    wait_out_valid("wait_ack", 40);
    n_tests++;
    if (out_data !== 8'h77) begin
      n_fail++;
      $display("FAIL wait_data: out_data=%h expected 77", out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_present;
    qf_ack = 8'hFF;
    qf_out = 8'hC3;
    in_valid = 1'b1;
    exp_q.push_back(8'hC3);
    step();
    in_valid = 1'b0;
    wait_out_valid("rst_mid", 20);
    reset_l = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, qf_clock, in_ready} !== 3'b001 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_abort: vld/qfclk/rdy=%b%b%b data=%h expected 001 00",
               out_valid, qf_clock, in_ready, out_data);
    end
    exp_q.delete();
    step();
    step();
    reset_l = 1'b1;
    repeat (4) step();
    test_nominal(8'h96);
  endtask

  // Watchdog: the run must end by itself
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Test sequence
  initial begin
    test_reset();
    test_nominal(8'hA5);
    test_partial_ack();
    test_backpressure();
    test_back_to_back();
    test_resolve_wait();
    test_reset_mid_present();
    repeat (3) step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d words never delivered expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
